// File: rtl/pmic_pkg.sv
// Shared definitions for the PMIC control slice (pi_duty_controller, pwm).
// Contents: the compensator FSM state type, ADC/duty widths and the default
// duty clamp limits that both the compensator and pwm build on.
package pmic_pkg;

  localparam int unsigned ADC_W  = 8;
  localparam int unsigned DUTY_W = 8;

  localparam int unsigned DEF_DUTY_MIN = 3;
  localparam int unsigned DEF_DUTY_MAX = 250;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    INTEG,
    SUM,
    OUT
  } ctrlState_t;

endpackage

// File: rtl/pi_duty_controller_if.sv
// Sample-in / duty-out path between the ADC read sequence and the compensator.
//   sample_valid, sample : one-cycle sample strobe and unsigned ADC code
//   duty, duty_valid     : registered duty command and its one-cycle update strobe
//   busy                 : compensator is processing a sample (new samples dropped)
// master = sample producer / duty consumer, slave = compensator.
interface pi_duty_controller_if;

  logic                         sample_valid;
  logic [pmic_pkg::ADC_W-1:0]   sample;
  logic [pmic_pkg::DUTY_W-1:0]  duty;
  logic                         duty_valid;
  logic                         busy;

  modport master (
    output sample_valid, sample,
    input  duty, duty_valid, busy
  );

  modport slave (
    input  sample_valid, sample,
    output duty, duty_valid, busy
  );

endinterface

// File: rtl/pi_duty_controller_soft_start_ramp.sv
// Soft-start reference generator: while enabled, ref rises by one code every
// SS_STEP_CYCLES clocks until it reaches SETPOINT, then holds there.
//   clk, reset : clock, synchronous active-high reset
//   enable     : 0 returns the ramp to zero
//   refLevel   : current reference in ADC codes
//   refDone    : registered, high once refLevel == SETPOINT
// SS_STEP_CYCLES is expected to be at least 2.
module soft_start_ramp
  import pmic_pkg::*;
#(
  parameter int unsigned SETPOINT       = 128,
  parameter int unsigned SS_STEP_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [ADC_W-1:0] refLevel,
  output logic             refDone
);

  localparam int unsigned CNT_W = (SS_STEP_CYCLES > 1) ? $clog2(SS_STEP_CYCLES) : 1;

  logic [CNT_W-1:0] stepCnt;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      stepCnt  <= '0;
      refLevel <= '0;
      refDone  <= 1'b0;
    end else begin
      refDone <= (refLevel == ADC_W'(SETPOINT));
      if (refLevel < ADC_W'(SETPOINT)) begin
        if (stepCnt == CNT_W'(SS_STEP_CYCLES - 1)) begin
          stepCnt  <= '0;
          refLevel <= refLevel + 1'b1;
        end else begin
          stepCnt <= stepCnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pi_duty_controller.sv
// PI voltage-loop compensator feeding pwm's duty target.
// Each accepted ADC sample walks IDLE->ERR->INTEG->SUM->OUT; the clamped duty
// appears with duty_valid four cycles after acceptance. An overvoltage latch
// trips after OV_COUNT consecutive samples >= OV_LIMIT and forces DUTY_MIN.
//   clk, reset  : clock, synchronous active-high reset
//   enable      : 0 holds the loop in its safe state (duty = DUTY_MIN)
//   fault_clear : request to clear ov_fault (honoured only if last sample < OV_LIMIT)
//   bus         : sample in / duty out / busy (slave side)
//   ov_fault    : latched overvoltage fault
//   ref_done    : soft start has reached SETPOINT
module pi_duty_controller
  import pmic_pkg::*;
#(
  parameter int unsigned SETPOINT       = 128,
  parameter int unsigned KP_SHIFT       = 2,
  parameter int unsigned KI_SHIFT       = 4,
  parameter int unsigned INT_W          = 16,
  parameter int unsigned DUTY_MIN       = DEF_DUTY_MIN,
  parameter int unsigned DUTY_MAX       = DEF_DUTY_MAX,
  parameter int unsigned SS_STEP_CYCLES = 1024,
  parameter int unsigned OV_LIMIT       = 240,
  parameter int unsigned OV_COUNT       = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fault_clear,
  pi_duty_controller_if.slave   bus,
  output logic                  ov_fault,
  output logic                  ref_done
);

  localparam int unsigned OV_CNT_W = $clog2(OV_COUNT + 1);
  localparam logic signed [INT_W:0]   INT_POS = $signed((INT_W+1)'((2**(INT_W-1)) - 1));
  localparam logic signed [INT_W:0]   INT_NEG = -INT_POS;
  localparam logic signed [INT_W+1:0] U_MAX   = (INT_W+2)'(DUTY_MAX);
  localparam logic signed [INT_W+1:0] U_MIN   = (INT_W+2)'(DUTY_MIN);

  ctrlState_t state, stateNext;

  logic [ADC_W-1:0]          refLevel;
  logic [ADC_W-1:0]          sReg;
  logic signed [ADC_W:0]     err;
  logic signed [INT_W-1:0]   integ;
  logic signed [INT_W+1:0]   u;
  logic                      satHi, satLo;
  logic [OV_CNT_W-1:0]       ovCnt;

  logic signed [ADC_W:0]     errNext;
  logic signed [INT_W:0]     integSum;
  logic signed [INT_W-1:0]   integSat;
  logic signed [INT_W+1:0]   errExt, integExt, uNext;
  logic [OV_CNT_W-1:0]       ovCntNext;
  logic                      windup;

  soft_start_ramp #(
    .SETPOINT       (SETPOINT),
    .SS_STEP_CYCLES (SS_STEP_CYCLES)
  ) u_ramp (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .refLevel (refLevel),
    .refDone  (ref_done)
  );

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (!enable) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.sample_valid) stateNext = ERR;
        ERR:     stateNext = INTEG;
        INTEG:   stateNext = SUM;
        SUM:     stateNext = OUT;
        OUT:     stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    errNext  = $signed({1'b0, refLevel}) - $signed({1'b0, sReg});
    integSum = $signed({integ[INT_W-1], integ})
             + $signed({{(INT_W-ADC_W){err[ADC_W]}}, err});
    if (integSum > INT_POS)      integSat = INT_POS[INT_W-1:0];
    else if (integSum < INT_NEG) integSat = INT_NEG[INT_W-1:0];
    else                         integSat = integSum[INT_W-1:0];
    windup   = (satHi && (err > 0)) || (satLo && (err < 0));
    errExt   = $signed({{(INT_W+1-ADC_W){err[ADC_W]}}, err});
    integExt = $signed({{2{integ[INT_W-1]}}, integ});
    uNext    = (errExt <<< KP_SHIFT) + (integExt >>> KI_SHIFT);
    if (sReg >= ADC_W'(OV_LIMIT))
      ovCntNext = (ovCnt == OV_CNT_W'(OV_COUNT)) ? ovCnt : ovCnt + 1'b1;
    else
      ovCntNext = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.duty       <= DUTY_W'(DUTY_MIN);
      bus.duty_valid <= 1'b0;
      ov_fault       <= 1'b0;
      ovCnt          <= '0;
      satHi          <= 1'b0;
      satLo          <= 1'b0;
      integ          <= '0;
      sReg           <= '0;
      err            <= '0;
      u              <= '0;
    end else begin
      bus.duty_valid <= 1'b0;
      if (fault_clear && (sReg < ADC_W'(OV_LIMIT))) begin
        ov_fault <= 1'b0;
        ovCnt    <= '0;
      end
      if (!enable) begin
        bus.duty <= DUTY_W'(DUTY_MIN);
        integ    <= '0;
      end else begin
        case (state)
          IDLE: if (bus.sample_valid) sReg <= bus.sample;
          ERR: begin
            // Placed after the clear request so a trip in this cycle wins.
            err   <= errNext;
            ovCnt <= ovCntNext;
            if (ovCntNext == OV_CNT_W'(OV_COUNT)) ov_fault <= 1'b1;
          end
          INTEG: begin
            if (ov_fault)     integ <= '0;
            else if (!windup) integ <= integSat;
          end
          SUM: u <= uNext;
          OUT: begin
            bus.duty_valid <= 1'b1;
            if (ov_fault) begin
              bus.duty <= DUTY_W'(DUTY_MIN);
              satHi    <= 1'b0;
              satLo    <= 1'b1;
            end else if (u > U_MAX) begin
              bus.duty <= DUTY_W'(DUTY_MAX);
              satHi    <= 1'b1;
              satLo    <= 1'b0;
            end else if (u < U_MIN) begin
              bus.duty <= DUTY_W'(DUTY_MIN);
              satHi    <= 1'b0;
              satLo    <= 1'b1;
            end else begin
              bus.duty <= u[DUTY_W-1:0];
              satHi    <= 1'b0;
              satLo    <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pi_duty_controller.sv
module tb_pi_duty_controller;

  localparam int SP   = 128;
  localparam int SS   = 4;
  localparam int KP   = 2;
  localparam int KI   = 4;
  localparam int INTW = 16;
  localparam int DMIN = 3;
  localparam int DMAX = 250;
  localparam int OVL  = 240;
  localparam int OVC  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic fault_clear = 1'b0;
  logic ov_fault, ref_done;

  pi_duty_controller_if bus();

  pi_duty_controller #(
    .SETPOINT(SP), .KP_SHIFT(KP), .KI_SHIFT(KI), .INT_W(INTW),
    .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .SS_STEP_CYCLES(SS),
    .OV_LIMIT(OVL), .OV_COUNT(OVC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .fault_clear(fault_clear),
    .bus(bus), .ov_fault(ov_fault), .ref_done(ref_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural loop model (reference settled at SP)
  int mInteg = 0, mOvCnt = 0, mLastS = 0;
  bit mSatHi = 0, mSatLo = 0, mFault = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int floorDiv(input int v, input int d);
    return (v >= 0) ? v / d : -((-v + d - 1) / d);
  endfunction

  task automatic modelSample(input int s, output int expDuty);
    int e, u, lim;
    lim = (1 << (INTW - 1)) - 1;
    e = SP - s;
    mLastS = s;
    if (s >= OVL) begin
      if (mOvCnt < OVC) mOvCnt++;
    end else begin
      mOvCnt = 0;
    end
    if (mOvCnt == OVC) mFault = 1;
    if (mFault) mInteg = 0;
    else if (!((mSatHi && e > 0) || (mSatLo && e < 0))) begin
      mInteg = mInteg + e;
      if (mInteg > lim) mInteg = lim;
      if (mInteg < -lim) mInteg = -lim;
    end
    u = e * (1 << KP) + floorDiv(mInteg, 1 << KI);
    if (mFault) begin
      mSatHi = 0; mSatLo = 1; expDuty = DMIN;
    end else if (u > DMAX) begin
      mSatHi = 1; mSatLo = 0; expDuty = DMAX;
    end else if (u < DMIN) begin
      mSatHi = 0; mSatLo = 1; expDuty = DMIN;
    end else begin
      mSatHi = 0; mSatLo = 0; expDuty = u;
    end
  endtask

  // Accept one sample and check the response at exactly 4 cycles.
  task automatic send(input int s, input string tag);
    int expDuty;
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 10) begin tick(); n++; end
    chk({tag, "_idle"}, bus.busy, 0);
    bus.sample = 8'(s);
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    modelSample(s, expDuty);
    chk({tag, "_busy"}, bus.busy, 1);
    tick(); tick(); tick();
    chk({tag, "_early"}, bus.duty_valid, 0);
    tick();
    chk({tag, "_valid"}, bus.duty_valid, 1);
    chk({tag, "_duty"}, bus.duty, expDuty);
    chk({tag, "_ovf"}, ov_fault, mFault);
  endtask

  task automatic faultClear(input string tag);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    if (mLastS < OVL) begin mFault = 0; mOvCnt = 0; end
    chk(tag, ov_fault, mFault);
  endtask

  initial begin
    int first, dropped, cnt, expDuty, s;
    bus.sample_valid = 1'b0;
    bus.sample = '0;

    // Reset state
    tick(); tick();
    chk("rst_duty", bus.duty, DMIN);
    chk("rst_dv", bus.duty_valid, 0);
    chk("rst_ovf", ov_fault, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_refdone", ref_done, 0);

    // Soft start
    reset = 1'b0;
    tick();
    enable = 1'b1;
    first = 0;
    dropped = 0;
    for (int i = 1; i <= 600; i++) begin
      tick();
      if (ref_done === 1'b1 && first == 0) first = i;
      if (first != 0 && ref_done !== 1'b1) dropped = 1;
    end
    chk("ramp_done_cycle", first, SP * SS + 1);
    chk("ramp_hold", dropped, 0);
    chk("ramp_duty_idle", bus.duty, DMIN);

    // Proportional + integral response
    send(120, "pi1"); chk("pi1_const", bus.duty, 32);
    send(120, "pi2"); chk("pi2_const", bus.duty, 33);

    // High clamp and anti-windup
    for (int i = 0; i < 10; i++) begin
      send(0, "wind");
      chk("wind_const", bus.duty, DMAX);
    end
    send(200, "lo1"); chk("lo1_const", bus.duty, DMIN);
    send(200, "lo2"); chk("lo2_const", bus.duty, DMIN);
    send(128, "hold"); chk("hold_const", bus.duty, 4);

    // Overvoltage latch and clearing
    send(245, "ov1");
    send(245, "ov2"); chk("ov2_nofault", ov_fault, 0);
    send(245, "ov3"); chk("ov3_fault", ov_fault, 1);
    chk("ov3_duty", bus.duty, DMIN);
    faultClear("clr_ignored"); chk("clr_ignored_const", ov_fault, 1);
    send(100, "ov_low"); chk("ov_low_duty", bus.duty, DMIN);
    faultClear("clr_ok"); chk("clr_ok_const", ov_fault, 0);
    send(120, "post_clr"); chk("post_clr_const", bus.duty, 32);

    // Sample while busy is dropped
    bus.sample = 8'd90;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    modelSample(90, expDuty);
    tick();
    bus.sample = 8'd250;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    tick();
    chk("drop_early", bus.duty_valid, 0);
    tick();
    chk("drop_valid", bus.duty_valid, 1);
    chk("drop_duty", bus.duty, expDuty);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.duty_valid === 1'b1) cnt++;
    end
    chk("drop_single", cnt, 0);

    // Randomized samples with occasional fault clears
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) s = int'($urandom_range(240, 255));
      else s = int'($urandom_range(0, 255));
      send(s, "rnd");
      if ($urandom_range(0, 4) == 0) faultClear("rnd_clr");
    end

    // enable low forces safe state, keeps fault latch
    enable = 1'b0;
    tick();
    mInteg = 0;
    chk("dis_duty", bus.duty, DMIN);
    chk("dis_refdone", ref_done, 0);
    chk("dis_busy", bus.busy, 0);
    chk("dis_ovf", ov_fault, mFault);
    enable = 1'b1;
    tick();

    // Reset while in SUM aborts without a duty_valid
    bus.sample = 8'd50;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    tick(); tick();
    chk("abort_busy", bus.busy, 1);
    reset = 1'b1;
    tick();
    chk("abort_dv", bus.duty_valid, 0);
    chk("abort_duty", bus.duty, DMIN);
    chk("abort_ovf", ov_fault, 0);
    chk("abort_busy0", bus.busy, 0);
    chk("abort_refdone", ref_done, 0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.duty_valid === 1'b1) cnt++;
    end
    chk("abort_no_dv", cnt, 0);
    chk("abort_duty_hold", bus.duty, DMIN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pi_duty_controller.md
Name: pi_duty_controller

Overview:
Digital voltage-loop compensator sitting directly upstream of the pwm block. It consumes each 8-bit ADC sample latched by pwm's ADC read sequence and computes a PI correction against a soft-started reference. It outputs a clamped 8-bit duty command that pwm uses as its duty target. It also provides an overvoltage fault latch that forces minimum duty.

Parameters:
SETPOINT, 128, final regulation reference in ADC codes
KP_SHIFT, 2, proportional gain = 2^KP_SHIFT
KI_SHIFT, 4, integral gain = 2^-KI_SHIFT
INT_W, 16, integrator width (signed)
DUTY_MIN, 3, lower duty clamp; also safe/idle duty
DUTY_MAX, 250, upper duty clamp
SS_STEP_CYCLES, 1024, clk cycles per +1 reference step during soft start
OV_LIMIT, 240, overvoltage threshold in ADC codes
OV_COUNT, 3, consecutive accepted samples >= OV_LIMIT needed to trip

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  loop enable; 0 holds loop in safe state
sample_valid  input  1  one-cycle strobe, sample is valid this cycle
sample  input  8  unsigned ADC code
fault_clear  input  1  one-cycle request to clear ov_fault
duty  output  8  duty command to pwm (registered)
duty_valid  output  1  one-cycle strobe, duty updated this cycle
ov_fault  output  1  latched overvoltage fault
busy  output  1  high while a sample is being processed
ref_done  output  1  soft start complete (ref == SETPOINT)

Behaviour:
- Reset is applied on the clk edge when reset=1. Reset values: duty=DUTY_MIN, duty_valid=0, ov_fault=0, busy=0, ref_done=0. Internally ref=0, integ=0, ov_cnt=0, sat_hi=sat_lo=0, FSM=IDLE.
- Soft start:
  - While enable=1 and ref<SETPOINT, a step counter increments each cycle.
  - When the counter reaches SS_STEP_CYCLES-1, it wraps to 0 and ref is incremented by 1.
  - ref_done=1 once ref==SETPOINT. ref holds at SETPOINT and never overshoots.
- enable=0:
  - FSM is forced to IDLE; duty=DUTY_MIN; integ=0; ref=0; step counter=0; ref_done=0.
  - ov_fault and ov_cnt are retained.
- FSM IDLE:
  - A sample_valid with enable=1 captures sample into s_reg; busy=1; next state ERR.
  - sample_valid while busy=1 is ignored: no capture, and no effect on ov_cnt.
- FSM ERR:
  - e = ref - s_reg, 9-bit signed.
  - OV check on s_reg: if s_reg >= OV_LIMIT, ov_cnt increments, saturating at OV_COUNT; otherwise ov_cnt=0.
  - ov_fault is set when ov_cnt reaches OV_COUNT.
  - Next state INTEG.
- FSM INTEG:
  - If ov_fault=1: integ=0.
  - Otherwise, anti-windup applies: integ is not updated if (sat_hi and e>0) or (sat_lo and e<0).
  - Otherwise integ = integ + e (sign-extended), saturated to [-(2^(INT_W-1)-1), 2^(INT_W-1)-1].
  - Next state SUM.
- FSM SUM:
  - u = (e <<< KP_SHIFT) + (integ >>> KI_SHIFT), computed signed at INT_W+2 bits with arithmetic shifts.
  - Next state OUT.
- FSM OUT:
  - If ov_fault=1: duty=DUTY_MIN, sat_hi=0, sat_lo=1.
  - Otherwise, clamp u:
    - u > DUTY_MAX: duty=DUTY_MAX, sat_hi=1, sat_lo=0.
    - u < DUTY_MIN: duty=DUTY_MIN, sat_lo=1, sat_hi=0.
    - Otherwise: duty=u[7:0], sat_hi=sat_lo=0.
  - duty_valid=1 for exactly this cycle; busy=0; next state IDLE.
- Latency: a sample accepted on cycle N produces duty and duty_valid on cycle N+4.
  - The earliest next accepted sample is cycle N+5.
  - Maximum throughput is 1 sample per 5 cycles.
- Fault clear:
  - fault_clear=1 clears ov_fault and ov_cnt only when the last captured s_reg < OV_LIMIT; otherwise the request is ignored.
  - If fault_clear=1 in the same cycle that ERR sets ov_fault, the set wins.
- Reset mid-operation: abort immediately to the reset values; no duty_valid is emitted.
- duty is only ever within [DUTY_MIN, DUTY_MAX] and changes only on duty_valid cycles, except when enable=0 or reset force it.

Decomposition:
- Shared package pmic_pkg holds:
  - FSM state encoding (IDLE, ERR, INTEG, SUM, OUT).
  - ADC_W=8 and DUTY_W=8 constants.
  - DUTY_MIN/DUTY_MAX defaults, reused by pwm.
- One natural sub-module: soft_start_ramp (step counter, ref, ref_done, enable-gated). The PI datapath and FSM stay in the top level.

Test Plan:
- Reset and defaults: after reset with enable=0 → duty=3, duty_valid=0, ov_fault=0, busy=0, ref_done=0.
- Soft start: SS_STEP_CYCLES=4, SETPOINT=8, enable=1 → ref reaches 8 after 32 cycles, ref_done=1 on the following cycle, ref holds at 8.
- Proportional/integral response: ref=128, integ=0, sample=120 → duty=32 exactly 4 cycles after sample_valid. A second sample=120 gives integ=16 → duty=33.
- Clamp and anti-windup: ref=128, sample=0 repeated 10 times → duty=250 each time. Integ stops growing after the first saturated output. Then sample=200 → duty=3 with sat_lo=1.
- Overvoltage: three accepted samples of 245 → ov_fault=1 after the third, duty=3, integ=0.
  - fault_clear with last sample 245 → ignored.
  - Then sample 100 followed by fault_clear → ov_fault=0.
- Busy drop and abort: sample_valid asserted 2 cycles after an accepted sample → ignored, and exactly one duty_valid is produced. Reset asserted in SUM → no duty_valid, and all outputs return to the reset values.
